// File: rtl/ysyx_25030093_csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause, ecall/mret handling, ID constants.
// Define YSYX_25030093_MCYCLE_EN to build the free-running 64-bit mcycle counter.
module ysyx_25030093_csr_file #(
  parameter logic [31:0] MVENDORID = 32'h7973_7978,
  parameter logic [31:0] MARCHID   = 32'h017E_AE1D,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csr_addr,
  input  logic        csr_ren,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_data,
  output logic        csr_illegal,
  input  logic        ecall_valid,
  input  logic [31:0] ecall_pc,
  input  logic        mret_valid,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  logic [31:0] w_mstatus;
  logic [31:0] w_rdata;
  logic        w_mapped;
  logic        w_readonly;
  logic        w_wr_ok;
  logic        w_unused;

  // MPP is hardwired to machine mode; only MIE and MPIE are real state.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};

  // Traps win over software writes; a colliding write is dropped completely.
  assign w_wr_ok  = csr_wen & ~ecall_valid & ~mret_valid;
  assign w_unused = &{1'b0, ecall_pc[1:0]};

`ifdef YSYX_25030093_MCYCLE_EN
  logic [63:0] r_mcycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcycle <= 64'd0;
    end else if (w_wr_ok && csr_addr == A_MCYCLE) begin
      r_mcycle[31:0] <= csr_wdata;
    end else if (w_wr_ok && csr_addr == A_MCYCLEH) begin
      r_mcycle[63:32] <= csr_wdata;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end
`endif

  always_comb begin
    w_rdata    = 32'd0;
    w_mapped   = 1'b1;
    w_readonly = 1'b0;
    case (csr_addr)
      A_MSTATUS:   w_rdata = w_mstatus;
      A_MTVEC:     w_rdata = r_mtvec;
      A_MEPC:      w_rdata = r_mepc;
      A_MCAUSE:    w_rdata = r_mcause;
`ifdef YSYX_25030093_MCYCLE_EN
      A_MCYCLE:    w_rdata = r_mcycle[31:0];
      A_MCYCLEH:   w_rdata = r_mcycle[63:32];
`endif
      A_MVENDORID: begin
        w_rdata    = MVENDORID;
        w_readonly = 1'b1;
      end
      A_MARCHID: begin
        w_rdata    = MARCHID;
        w_readonly = 1'b1;
      end
      default:     w_mapped = 1'b0;
    endcase
  end

  assign csr_data    = w_rdata;
  assign csr_illegal = (csr_ren & ~w_mapped) | (csr_wen & w_readonly);
  assign mtvec_o     = r_mtvec;
  assign mepc_o      = r_mepc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtvec  <= MTVEC_RST;
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
    end else if (ecall_valid) begin
      r_mepc   <= {ecall_pc[31:2], 2'b00};
      r_mcause <= 32'd11;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (mret_valid) begin
      r_mie    <= r_mpie;
      r_mpie   <= 1'b1;
    end else if (w_wr_ok) begin
      case (csr_addr)
        A_MSTATUS: begin
          r_mie  <= csr_wdata[3];
          r_mpie <= csr_wdata[7];
        end
        A_MTVEC:  r_mtvec  <= {csr_wdata[31:2], 2'b00};
        A_MEPC:   r_mepc   <= {csr_wdata[31:2], 2'b00};
        A_MCAUSE: r_mcause <= csr_wdata;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_csr_file.sv
// Directed bench for ysyx_25030093_csr_file; mcycle scenarios follow YSYX_25030093_MCYCLE_EN.
module tb_ysyx_25030093_csr_file;

  logic        clk;
  logic        reset;
  logic [11:0] csr_addr;
  logic        csr_ren;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_data;
  logic        csr_illegal;
  logic        ecall_valid;
  logic [31:0] ecall_pc;
  logic        mret_valid;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_25030093_csr_file dut (
    .clk         (clk),
    .reset       (reset),
    .csr_addr    (csr_addr),
    .csr_ren     (csr_ren),
    .csr_wen     (csr_wen),
    .csr_wdata   (csr_wdata),
    .csr_data    (csr_data),
    .csr_illegal (csr_illegal),
    .ecall_valid (ecall_valid),
    .ecall_pc    (ecall_pc),
    .mret_valid  (mret_valid),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_ren     = 1'b0;
    csr_wen     = 1'b0;
    ecall_valid = 1'b0;
    mret_valid  = 1'b0;
  endtask

  task automatic set_rd(input logic [11:0] a);
    csr_addr = a;
    csr_ren  = 1'b1;
    csr_wen  = 1'b0;
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_ren   = 1'b1;
    csr_wen   = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1800) begin
      n_errors++; $display("FAIL reset_mstatus_in_reset got %h exp %h", csr_data, 32'h0000_1800);
    end
    reset = 1'b1;
    tick();
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1800 || csr_illegal !== 1'b0) begin
      n_errors++; $display("FAIL reset_mstatus got %h/%b exp 00001800/0", csr_data, csr_illegal);
    end
    set_rd(12'h305);
    n_checks++;
    if (csr_data !== 32'h0 || mtvec_o !== 32'h0 || mepc_o !== 32'h0) begin
      n_errors++; $display("FAIL reset_mtvec got %h/%h/%h exp 0/0/0", csr_data, mtvec_o, mepc_o);
    end
    set_rd(12'hF11);
    n_checks++;
    if (csr_data !== 32'h7973_7978 || csr_illegal !== 1'b0) begin
      n_errors++; $display("FAIL reset_mvendorid got %h/%b exp 79737978/0", csr_data, csr_illegal);
    end
    tick();
    set_rd(12'hF12);
    n_checks++;
    if (csr_data !== 32'h017E_AE1D) begin
      n_errors++; $display("FAIL reset_marchid got %h exp 017eae1d", csr_data);
    end
    set_rd(12'h342);
    n_checks++;
    if (csr_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_mcause got %h exp 0", csr_data);
    end
    idle();
  endtask

  task automatic test_mtvec_write();
    tick();
    csr_addr  = 12'h305;
    csr_wdata = 32'h8000_0107;
    csr_ren   = 1'b1;
    csr_wen   = 1'b1;
    #1;
    n_checks++;
    if (csr_data !== 32'h0 || csr_illegal !== 1'b0) begin
      n_errors++; $display("FAIL mtvec_same_cycle got %h/%b exp 0/0", csr_data, csr_illegal);
    end
    tick();
    idle();
    set_rd(12'h305);
    n_checks++;
    if (csr_data !== 32'h8000_0104 || mtvec_o !== 32'h8000_0104) begin
      n_errors++; $display("FAIL mtvec_after got %h/%h exp 80000104", csr_data, mtvec_o);
    end
    do_write(12'h341, 32'h1234_5677);
    set_rd(12'h341);
    n_checks++;
    if (csr_data !== 32'h1234_5674 || mepc_o !== 32'h1234_5674) begin
      n_errors++; $display("FAIL mepc_write got %h/%h exp 12345674", csr_data, mepc_o);
    end
  endtask

  task automatic test_mstatus_write();
    do_write(12'h300, 32'hFFFF_FFFF);
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1888) begin
      n_errors++; $display("FAIL mstatus_all_ones got %h exp 00001888", csr_data);
    end
    do_write(12'h300, 32'h0000_0000);
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1800) begin
      n_errors++; $display("FAIL mstatus_zero got %h exp 00001800", csr_data);
    end
  endtask

  task automatic test_ecall_mret();
    do_write(12'h300, 32'h0000_0008);
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1808) begin
      n_errors++; $display("FAIL mstatus_set_mie got %h exp 00001808", csr_data);
    end
    ecall_pc    = 32'h8000_0022;
    ecall_valid = 1'b1;
    tick();
    idle();
    set_rd(12'h341);
    n_checks++;
    if (csr_data !== 32'h8000_0020 || mepc_o !== 32'h8000_0020) begin
      n_errors++; $display("FAIL ecall_mepc got %h/%h exp 80000020", csr_data, mepc_o);
    end
    set_rd(12'h342);
    n_checks++;
    if (csr_data !== 32'd11) begin
      n_errors++; $display("FAIL ecall_mcause got %h exp 0000000b", csr_data);
    end
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1880) begin
      n_errors++; $display("FAIL ecall_mstatus got %h exp 00001880", csr_data);
    end
    mret_valid = 1'b1;
    tick();
    idle();
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1888) begin
      n_errors++; $display("FAIL mret_mstatus got %h exp 00001888", csr_data);
    end
  endtask

  task automatic test_priority();
    do_write(12'h342, 32'h0000_0007);
    set_rd(12'h342);
    n_checks++;
    if (csr_data !== 32'h7) begin
      n_errors++; $display("FAIL mcause_write got %h exp 00000007", csr_data);
    end
    // MIE=1, MPIE=1 going in
    csr_addr    = 12'h342;
    csr_wdata   = 32'd5;
    csr_wen     = 1'b1;
    ecall_valid = 1'b1;
    mret_valid  = 1'b1;
    ecall_pc    = 32'h0000_0103;
    tick();
    idle();
    set_rd(12'h342);
    n_checks++;
    if (csr_data !== 32'd11 || mepc_o !== 32'h0000_0100) begin
      n_errors++; $display("FAIL prio_ecall_mcause got %h/%h exp 0000000b/00000100", csr_data, mepc_o);
    end
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1880) begin
      n_errors++; $display("FAIL prio_ecall_mstatus got %h exp 00001880", csr_data);
    end
    // mret alongside a write to an untouched register: write still discarded
    csr_addr   = 12'h305;
    csr_wdata  = 32'h0000_0040;
    csr_wen    = 1'b1;
    mret_valid = 1'b1;
    tick();
    idle();
    set_rd(12'h305);
    n_checks++;
    if (mtvec_o !== 32'h8000_0104 || csr_data !== 32'h8000_0104) begin
      n_errors++; $display("FAIL prio_mret_drop got %h exp 80000104", mtvec_o);
    end
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1888) begin
      n_errors++; $display("FAIL prio_mret_mstatus got %h exp 00001888", csr_data);
    end
  endtask

  task automatic test_illegal();
    tick();
    csr_addr  = 12'hF12;
    csr_wdata = 32'hDEAD_BEEF;
    csr_ren   = 1'b1;
    csr_wen   = 1'b1;
    #1;
    n_checks++;
    if (csr_illegal !== 1'b1) begin
      n_errors++; $display("FAIL ro_write_illegal got %b exp 1", csr_illegal);
    end
    tick();
    idle();
    set_rd(12'hF12);
    n_checks++;
    if (csr_data !== 32'h017E_AE1D || csr_illegal !== 1'b0) begin
      n_errors++; $display("FAIL ro_unchanged got %h/%b exp 017eae1d/0", csr_data, csr_illegal);
    end
    set_rd(12'h123);
    n_checks++;
    if (csr_data !== 32'h0 || csr_illegal !== 1'b1) begin
      n_errors++; $display("FAIL unmapped_read got %h/%b exp 0/1", csr_data, csr_illegal);
    end
    csr_ren = 1'b0;
    csr_wen = 1'b1;
    #1;
    n_checks++;
    if (csr_illegal !== 1'b0) begin
      n_errors++; $display("FAIL unmapped_wen_only got %b exp 0", csr_illegal);
    end
    idle();
  endtask

  task automatic test_mcycle();
`ifdef YSYX_25030093_MCYCLE_EN
    do_write(12'hB80, 32'h0000_0005);
    do_write(12'hB00, 32'hFFFF_FFFE);
    tick();
    tick();
    tick();
    set_rd(12'hB00);
    n_checks++;
    if (csr_data !== 32'h0000_0001 || csr_illegal !== 1'b0) begin
      n_errors++; $display("FAIL mcycle_low got %h/%b exp 00000001/0", csr_data, csr_illegal);
    end
    set_rd(12'hB80);
    n_checks++;
    if (csr_data !== 32'h0000_0006) begin
      n_errors++; $display("FAIL mcycle_high_carry got %h exp 00000006", csr_data);
    end
    do_write(12'hB80, 32'hFFFF_FFFF);
    set_rd(12'hB00);
    n_checks++;
    if (csr_data !== 32'h0000_0001) begin
      n_errors++; $display("FAIL mcycle_hold_on_write got %h exp 00000001", csr_data);
    end
    do_write(12'hB00, 32'hFFFF_FFFF);
    tick();
    set_rd(12'hB00);
    n_checks++;
    if (csr_data !== 32'h0) begin
      n_errors++; $display("FAIL mcycle_wrap_low got %h exp 0", csr_data);
    end
    set_rd(12'hB80);
    n_checks++;
    if (csr_data !== 32'h0) begin
      n_errors++; $display("FAIL mcycle_wrap_high got %h exp 0", csr_data);
    end
`else
    do_write(12'hB00, 32'h1234_5678);
    set_rd(12'hB00);
    n_checks++;
    if (csr_data !== 32'h0 || csr_illegal !== 1'b1) begin
      n_errors++; $display("FAIL mcycle_off_low got %h/%b exp 0/1", csr_data, csr_illegal);
    end
    set_rd(12'hB80);
    n_checks++;
    if (csr_data !== 32'h0 || csr_illegal !== 1'b1) begin
      n_errors++; $display("FAIL mcycle_off_high got %h/%b exp 0/1", csr_data, csr_illegal);
    end
`endif
    idle();
  endtask

  task automatic test_reset_mid();
    tick();
    csr_addr  = 12'h305;
    csr_wdata = 32'h0000_0040;
    csr_wen   = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (mtvec_o !== 32'h0 || mepc_o !== 32'h0) begin
      n_errors++; $display("FAIL async_reset got %h/%h exp 0/0", mtvec_o, mepc_o);
    end
    tick();
    idle();
    reset = 1'b1;
    tick();
    set_rd(12'h305);
    n_checks++;
    if (csr_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_drops_write got %h exp 0", csr_data);
    end
    set_rd(12'h300);
    n_checks++;
    if (csr_data !== 32'h0000_1800) begin
      n_errors++; $display("FAIL reset_mid_mstatus got %h exp 00001800", csr_data);
    end
    idle();
  endtask

  initial begin
    reset     = 1'b0;
    csr_addr  = 12'h0;
    csr_wdata = 32'h0;
    ecall_pc  = 32'h0;
    idle();
    tick();
    tick();
    test_reset();
    test_mtvec_write();
    test_mstatus_write();
    test_ecall_mret();
    test_priority();
    test_illegal();
    test_mcycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_25030093_csr_file.md
Name: ysyx_25030093_csr_file

Overview:
- Machine-mode CSR register file serving the ALU's CSR read/modify path (csrrw/csrrs).
- Supplies csr_data combinationally for the addressed CSR and commits the ALU's csr_wdata on the clock edge.
- Handles ecall trap entry and mret return; exports mtvec and mepc to the PC-select logic.
- Optionally maintains a free-running 64-bit mcycle counter.

Parameters:
- MVENDORID, 32'h7973_7978, constant returned at 0xF11.
- MARCHID, 32'h017E_AE1D, constant returned at 0xF12.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- csr_addr  in  12  CSR address of the current instruction.
- csr_ren  in  1  CSR instruction in execute; qualifies illegal-address detection.
- csr_wen  in  1  commit csr_wdata to csr_addr at the next edge.
- csr_wdata  in  32  write data from the ALU.
- csr_data  out  32  combinational read data for csr_addr.
- csr_illegal  out  1  combinational; high when csr_ren=1 and the address is unmapped, or when csr_wen=1 and the address is read-only.
- ecall_valid  in  1  ecall retiring this cycle.
- ecall_pc  in  32  PC of the ecall instruction.
- mret_valid  in  1  mret retiring this cycle.
- mtvec_o  out  32  current mtvec, used as the trap target.
- mepc_o  out  32  current mepc, used as the mret target.

Behaviour:
- Address map:
  - 0x300 mstatus
  - 0x305 mtvec
  - 0x341 mepc
  - 0x342 mcause
  - 0xB00 mcycle[31:0]
  - 0xB80 mcycle[63:32]
  - 0xF11 / 0xF12 read-only constants
  - Every other address reads 0.
- Reset (reset=0, asynchronous): mstatus=32'h0000_1800 (MPP=11), mtvec=MTVEC_RST, mepc=0, mcause=0, mcycle=0. Outputs follow from these values; csr_illegal depends only on its inputs.
- Reads: zero latency; csr_data reflects register state before the current edge, never the same-cycle write.
- Writes: take effect at the edge; visible on csr_data the following cycle.
  - mtvec and mepc: bits [1:0] forced to 0.
  - mstatus: only MIE[3], MPIE[7] and MPP[12:11] are writable; other bits read 0. MPP is fixed at 2'b11.
  - Writes to 0xF11, 0xF12 or unmapped addresses are dropped.
- ecall_valid (one edge):
  - mepc <= {ecall_pc[31:2],2'b00}, mcause <= 32'd11.
  - mstatus.MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
- mret_valid (one edge): MIE <= MPIE, MPIE <= 1, MPP stays 2'b11.
- Simultaneous-event priority: ecall > mret > csr write.
  - A csr_wen coinciding with ecall_valid or mret_valid is discarded entirely, including writes to registers the trap does not touch.
- mcycle:
  - Increments by 1 every edge out of reset; wraps 2^64-1 -> 0.
  - A CSR write to either half in the same cycle replaces that half and suppresses the increment for that cycle. The other half holds.
  - No carry out of a written low half.
- Reset assertion mid-operation discards any pending write; deassertion needs no cycle-alignment beyond the external synchronizer.

Optional Feature:
- Macro: YSYX_25030093_MCYCLE_EN.
- Defined: mcycle exists as above.
- Undefined:
  - No counter flops are instantiated.
  - 0xB00 and 0xB80 read 0 and are treated as unmapped: csr_illegal fires on csr_ren, and writes are dropped.

Test Plan:
- Reset release, then read 0x300, 0x305, 0xF11 -> 0x00001800, MTVEC_RST, 0x79737978; csr_illegal=0.
- csr_wen=1, addr 0x305, wdata 0x80000107 -> next cycle csr_data=0x80000104 and mtvec_o=0x80000104; same-cycle csr_data still shows the old value.
- Set MIE via write 0x00000008 to 0x300, then ecall_valid with ecall_pc=0x80000022 ->
  - mepc=0x80000020, mcause=11, mstatus=0x00001880.
  - Then mret_valid -> mstatus=0x00001888.
- ecall_valid, mret_valid and csr_wen (addr 0x342, data 5) in the same cycle -> ecall effects only; mcause=11, MIE=0, MPIE=old MIE.
- Preload mcycle low half with 0xFFFFFFFE, then idle 3 cycles -> low half = 0x00000001, high half incremented by 1.
- Write 0xDEADBEEF to 0xF12 -> csr_illegal=1 that cycle; the value is unchanged afterwards. csr_ren to 0x123 -> csr_illegal=1, csr_data=0.
